// File: rtl/imm_pkg.sv
// imm_pkg -- shared definitions for the immediate-decode stage.
//   fmt_e    : format select / resolved format codes (NONE, I, S, B, J, U, AUTO)
//   OP_*     : RV32 major opcodes used by AUTO format resolution
//   skid_st_e: occupancy states of the two-entry skid buffer
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_J    = 3'd4,
      FMT_U    = 3'd5,
      FMT_RSVD = 3'd6,   // reserved select, decodes as none
      FMT_AUTO = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_st_e;

endpackage

// File: rtl/imm_extract.sv
// imm_extract -- combinational format resolution and immediate extraction.
// Ports:
//   instr [31:0]     raw RV32 instruction word
//   sel   [2:0]      format select (0 none, 1 I, 2 S, 3 B, 4 J, 5 U, 6 none, 7 AUTO)
//   imm   [XLEN-1:0] immediate sign-extended from instr[31]; zero for none
//   fmt   [2:0]      resolved format code (1..5, or 0 for none)
//   err              AUTO hit an unknown opcode, or select 6 was used
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      sel,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            err
);

   fmt_e        res;
   logic [31:0] imm32;

   always_comb begin
      res = FMT_NONE;
      case (sel)
         FMT_I, FMT_S, FMT_B, FMT_J, FMT_U: res = fmt_e'(sel);
         FMT_AUTO: begin
            case (instr[6:0])
               OP_IMM, OP_LOAD, OP_JALR: res = FMT_I;
               OP_STORE:                 res = FMT_S;
               OP_BRANCH:                res = FMT_B;
               OP_JAL:                   res = FMT_J;
               OP_LUI, OP_AUIPC:         res = FMT_U;
               default:                  res = FMT_NONE;
            endcase
         end
         default: res = FMT_NONE;
      endcase
   end

   always_comb begin
      imm32 = 32'd0;
      case (res)
         FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_U: imm32 = {instr[31:12], 12'd0};
         default: imm32 = 32'd0;
      endcase
   end

   // Replicating bit 31 (XLEN-31) times covers both XLEN=32 (count 1) and 64.
   assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
   assign fmt = res;
   assign err = ((sel == FMT_AUTO) && (res == FMT_NONE)) || (sel == FMT_RSVD);

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage -- pipeline stage that decodes an RV32 immediate at
// acceptance and holds the decoded result in a 2-entry skid buffer.
// Optional feature: define IMM_DECODE_ERR_EN to add the out_err port.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          upstream handshake (in_ready from state only)
//   in_instr, in_sel, in_tag   instruction, format select, sideband tag
//   out_valid/out_ready        downstream handshake
//   out_imm, out_fmt, out_tag  decoded immediate, resolved format, tag
//   out_err (optional)         result resolved to none (unknown opcode / sel 6)
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag
`ifdef IMM_DECODE_ERR_EN
   ,
   output logic             out_err
`endif
);

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_err;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr (in_instr),
      .sel   (in_sel),
      .imm   (dec_imm),
      .fmt   (dec_fmt),
      .err   (dec_err)
   );

   skid_st_e state_reg, state_next;
   logic     accept, drain;
   logic     load_head, head_from_skid, load_skid;

   // Entry 0 is the head presented on out_*; entry 1 is the skid slot.
   logic [XLEN-1:0]  imm_reg [2];
   logic [2:0]       fmt_reg [2];
   logic [TAG_W-1:0] tag_reg [2];

   assign in_ready  = (state_reg != ST_FULL);
   assign out_valid = (state_reg != ST_EMPTY);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= ST_EMPTY;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      load_head      = 1'b0;
      head_from_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               load_head  = 1'b1;
               state_next = ST_ONE;
            end
         end
         ST_ONE: begin
            case ({accept, drain})
               2'b11: load_head = 1'b1;       // replace head, stay ONE
               2'b10: begin
                  load_skid  = 1'b1;
                  state_next = ST_FULL;
               end
               2'b01: state_next = ST_EMPTY;
               default: ;
            endcase
         end
         ST_FULL: begin
            if (drain) begin
               load_head      = 1'b1;
               head_from_skid = 1'b1;
               state_next     = ST_ONE;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            imm_reg[i] <= '0;
            fmt_reg[i] <= '0;
            tag_reg[i] <= '0;
         end
      end else begin
         if (load_head) begin
            imm_reg[0] <= head_from_skid ? imm_reg[1] : dec_imm;
            fmt_reg[0] <= head_from_skid ? fmt_reg[1] : dec_fmt;
            tag_reg[0] <= head_from_skid ? tag_reg[1] : in_tag;
         end
         if (load_skid) begin
            imm_reg[1] <= dec_imm;
            fmt_reg[1] <= dec_fmt;
            tag_reg[1] <= in_tag;
         end
      end
   end

   assign out_imm = imm_reg[0];
   assign out_fmt = fmt_reg[0];
   assign out_tag = tag_reg[0];

`ifdef IMM_DECODE_ERR_EN
   logic err_reg [2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_reg[0] <= 1'b0;
         err_reg[1] <= 1'b0;
      end else begin
         if (load_head) err_reg[0] <= head_from_skid ? err_reg[1] : dec_err;
         if (load_skid) err_reg[1] <= dec_err;
      end
   end

   assign out_err = err_reg[0];
`else
   logic unused_dec_err;
   assign unused_dec_err = dec_err;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;
   import imm_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_sel;
   logic [3:0]  in_tag;
   logic        out_ready;

   logic        in_ready,  out_valid;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic [3:0]  out_tag;
   logic        in_ready64, out_valid64;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt64;
   logic [3:0]  out_tag64;
`ifdef IMM_DECODE_ERR_EN
   logic        out_err, out_err64;
`endif

   int passed = 0;
   int total  = 0;

   imm_decode_stage #(.XLEN(32), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag)
`ifdef IMM_DECODE_ERR_EN
      , .out_err(out_err)
`endif
   );

   imm_decode_stage #(.XLEN(64), .TAG_W(4)) dut64 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
`ifdef IMM_DECODE_ERR_EN
      , .out_err(out_err64)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] sel,
                        input logic [3:0] tag);
      in_valid = v;
      in_instr = instr;
      in_sel   = sel;
      in_tag   = tag;
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 32'hFFF00093, FMT_AUTO, 4'd9);   // must be ignored in reset
      tick();
      tick();
      $display("reset: valid=%0b imm=%h fmt=%0d tag=%0d", out_valid, out_imm, out_fmt, out_tag);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_imm",   out_imm,   0);
      check("rst_out_fmt",   out_fmt,   0);
      check("rst_out_tag",   out_tag,   0);
      check("rst_in_ready",  in_ready,  1);

      rst_n = 1'b1;
      drive(1'b1, 32'hFFF00093, FMT_AUTO, 4'd5);   // addi x1,x0,-1
      tick();
      $display("addi: valid=%0b imm=%h fmt=%0d tag=%0d", out_valid, out_imm, out_fmt, out_tag);
      check("addi_valid", out_valid, 1);
      check("addi_imm",   out_imm,   64'hFFFFFFFF);
      check("addi_fmt",   out_fmt,   1);
      check("addi_tag",   out_tag,   5);

      drive(1'b1, 32'hFE000EE3, FMT_AUTO, 4'd6);   // beq -4
      tick();
      $display("beq: imm=%h fmt=%0d tag=%0d", out_imm, out_fmt, out_tag);
      check("beq_imm", out_imm, 64'hFFFFFFFC);
      check("beq_fmt", out_fmt, 3);
      check("beq_tag", out_tag, 6);

      drive(1'b1, 32'h008000EF, FMT_AUTO, 4'd7);   // jal +8
      tick();
      $display("jal: imm=%h fmt=%0d tag=%0d", out_imm, out_fmt, out_tag);
      check("jal_imm", out_imm, 64'h00000008);
      check("jal_fmt", out_fmt, 4);

      drive(1'b1, 32'h800002B7, FMT_AUTO, 4'd8);   // lui
      tick();
      $display("lui: imm32=%h imm64=%h fmt=%0d", out_imm, out_imm64, out_fmt64);
      check("lui_imm32", out_imm,   64'h80000000);
      check("lui_imm64", out_imm64, 64'hFFFFFFFF80000000);
      check("lui_fmt64", out_fmt64, 5);

      drive(1'b1, 32'h0000007F, FMT_AUTO, 4'd9);   // unknown opcode
      tick();
      $display("unknown: imm=%h fmt=%0d tag=%0d", out_imm, out_fmt, out_tag);
      check("unk_imm", out_imm, 0);
      check("unk_fmt", out_fmt, 0);
      check("unk_tag", out_tag, 9);
`ifdef IMM_DECODE_ERR_EN
      check("unk_err", out_err, 1);
`endif

      drive(1'b1, 32'h00A12423, FMT_I, 4'd10);     // forced I on a store word
      tick();
      $display("force_i: imm=%h fmt=%0d", out_imm, out_fmt);
      check("force_i_imm", out_imm, 64'h0000000A);
      check("force_i_fmt", out_fmt, 1);
`ifdef IMM_DECODE_ERR_EN
      check("force_i_err", out_err, 0);
`endif

      drive(1'b1, 32'h00A12423, FMT_S, 4'd11);
      tick();
      $display("force_s: imm=%h fmt=%0d", out_imm, out_fmt);
      check("force_s_imm", out_imm, 64'h00000008);
      check("force_s_fmt", out_fmt, 2);

      drive(1'b1, 32'hFFF00093, FMT_RSVD, 4'd12);
      tick();
      $display("sel6: imm=%h fmt=%0d", out_imm, out_fmt);
      check("sel6_imm", out_imm, 0);
      check("sel6_fmt", out_fmt, 0);
`ifdef IMM_DECODE_ERR_EN
      check("sel6_err", out_err, 1);
`endif

      drive(1'b1, 32'hFFF00093, FMT_NONE, 4'd13);
      tick();
      $display("sel0: imm=%h fmt=%0d", out_imm, out_fmt);
      check("sel0_imm", out_imm, 0);
      check("sel0_fmt", out_fmt, 0);

      drive(1'b0, 32'h0, FMT_NONE, 4'd0);
      tick();
      $display("drain: valid=%0b", out_valid);
      check("drain_valid", out_valid, 0);

      // Backpressure: three back-to-back inputs with out_ready low.
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, FMT_AUTO, 4'd1);
      tick();
      $display("stall1: valid=%0b tag=%0d in_ready=%0b", out_valid, out_tag, in_ready);
      check("stall1_tag",   out_tag,  1);
      check("stall1_ready", in_ready, 1);

      drive(1'b1, 32'h008000EF, FMT_AUTO, 4'd2);
      tick();
      $display("stall2: tag=%0d in_ready=%0b", out_tag, in_ready);
      check("stall2_tag",   out_tag,  1);
      check("stall2_ready", in_ready, 0);

      drive(1'b1, 32'hFE000EE3, FMT_AUTO, 4'd3);   // held until accepted
      tick();
      $display("stall3: tag=%0d imm=%h fmt=%0d in_ready=%0b", out_tag, out_imm, out_fmt, in_ready);
      check("stall3_tag",   out_tag,  1);
      check("stall3_imm",   out_imm,  64'hFFFFFFFF);
      check("stall3_fmt",   out_fmt,  1);
      check("stall3_ready", in_ready, 0);

      out_ready = 1'b1;
      tick();
      $display("rel1: valid=%0b tag=%0d imm=%h", out_valid, out_tag, out_imm);
      check("rel1_tag",   out_tag,  2);
      check("rel1_imm",   out_imm,  64'h00000008);
      check("rel1_ready", in_ready, 1);

      tick();
      $display("rel2: valid=%0b tag=%0d imm=%h", out_valid, out_tag, out_imm);
      check("rel2_valid", out_valid, 1);
      check("rel2_tag",   out_tag,   3);
      check("rel2_imm",   out_imm,   64'hFFFFFFFC);

      drive(1'b0, 32'h0, FMT_NONE, 4'd0);
      tick();
      $display("rel3: valid=%0b", out_valid);
      check("rel3_valid", out_valid, 0);

      // Reset while FULL discards both entries.
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, FMT_AUTO, 4'd4);
      tick();
      drive(1'b1, 32'h008000EF, FMT_AUTO, 4'd5);
      tick();
      $display("fill: in_ready=%0b tag=%0d", in_ready, out_tag);
      check("fill_ready", in_ready, 0);
      rst_n = 1'b0;
      tick();
      $display("rst_full: valid=%0b in_ready=%0b tag=%0d imm=%h", out_valid, in_ready, out_tag, out_imm);
      check("rstfull_valid", out_valid, 0);
      check("rstfull_ready", in_ready,  1);
      check("rstfull_tag",   out_tag,   0);
      check("rstfull_imm",   out_imm,   0);
      rst_n = 1'b1;
      drive(1'b0, 32'h0, FMT_NONE, 4'd0);
      tick();
      $display("post_rst: valid=%0b", out_valid);
      check("postrst_valid", out_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, output datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-007 SHALL have port in_instr  input  32  raw RV32 instruction word.
REQ-008 SHALL have port in_sel  input  3  format select: 0 none, 1 I, 2 S, 3 B, 4 J, 5 U, 7 AUTO; 6 treated as none.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-013 SHALL have port out_fmt  output  3  resolved format code (1..5, or 0 for none).
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the presented result.

Function
REQ-015 SHALL complete an input transfer when in_valid and in_ready are both high at a clock edge, and an output transfer when out_valid and out_ready are both high.
REQ-016 SHALL present a transferred instruction's result on out_* exactly one cycle after acceptance when the stage was empty (latency 1).
REQ-017 SHALL contain a 2-entry skid buffer with states EMPTY, ONE, FULL: EMPTY->ONE on accept; ONE->FULL on accept without drain; ONE->EMPTY on drain without accept; ONE stays on simultaneous accept and drain; FULL->ONE on drain; FULL accepts nothing.
REQ-018 SHALL drive in_ready = (state != FULL), decoded from registered state only, with no combinational path from out_ready.
REQ-019 SHALL sustain one transfer per cycle when out_ready stays high, and SHALL preserve strict FIFO order.
REQ-020 SHALL hold out_imm, out_fmt and out_tag stable while out_valid is high and out_ready is low.
REQ-021 SHALL, for AUTO, resolve the format from in_instr[6:0]: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 1101111 -> J; 0110111/0010111 -> U; otherwise none.
REQ-022 SHALL form the immediates as: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}; U = {instr[31:12],12'b0}; each sign-extended from instr[31] to XLEN.
REQ-023 SHALL output out_imm = 0 and out_fmt = 0 for format none.
REQ-024 SHALL compute the immediate at acceptance and store only the decoded result, never the raw instruction.

Reset
REQ-025 SHALL, on a clock edge with rst_n low, set state EMPTY, out_valid 0, out_imm 0, out_fmt 0, out_tag 0, discarding any buffered entries, including mid-stall.
REQ-026 SHALL ignore in_valid on edges where rst_n is low, and SHALL show in_ready = 1 from the first edge after reset.

Configuration
REQ-027 SHALL, with macro IMM_DECODE_ERR_EN defined, add port out_err  output  1, high with a result whose format resolved to none under AUTO (unknown opcode) or whose in_sel was 6, buffered alongside the entry and reset to 0.
REQ-028 SHALL, without IMM_DECODE_ERR_EN, omit out_err and its storage entirely; all other behaviour identical.

Structure
REQ-029 SHALL take format codes (NONE, I, S, B, J, U, AUTO) and opcode constants from shared package imm_pkg.
REQ-030 SHALL place the combinational format resolution and extraction in sub-module imm_extract (parameter XLEN), instantiated once ahead of the skid buffer.

Verification
REQ-031 SHALL verify: 0xFFF00093, sel AUTO, out_ready=1 -> next cycle out_imm 0xFFFFFFFF, out_fmt I.
REQ-032 SHALL verify: 0xFE000EE3 (beq -4) AUTO -> out_imm 0xFFFFFFFC, fmt B; 0x008000EF (jal +8) -> out_imm 0x00000008, fmt J.
REQ-033 SHALL verify: XLEN=64, 0x800002B7 (lui) AUTO -> out_imm 0xFFFFFFFF80000000, fmt U.
REQ-034 SHALL verify: out_ready low, 3 back-to-back valid inputs tags 1,2,3 -> 2 accepted, in_ready low after second; release out_ready -> tags 1,2,3 emerge in order, none lost or duplicated.
REQ-035 SHALL verify: 0x0000007F AUTO with IMM_DECODE_ERR_EN -> out_imm 0, fmt 0, out_err 1; rst_n low while FULL -> next cycle out_valid 0, in_ready 1.
